// File: rtl/pc_fetch_unit.sv
// Program counter and instruction register with a bounded req/ack fetch
// from instruction memory; IR feeds the control unit's decode input.
module pc_fetch_unit #(
  parameter int unsigned            ADDR_W    = 8,
  parameter int unsigned            INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
  parameter int unsigned            TIMEOUT   = 16,
  parameter logic [INSTR_W-1:0]     ERR_INSTR = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PC_CLR,
  input  logic               PC_LD,
  input  logic [ADDR_W-1:0]  PC_LD_VAL,
  input  logic               PC_IC,
  input  logic               IR_LD,
  input  logic               IM_ACK,
  input  logic [INSTR_W-1:0] IM_RDATA,
  output logic               IM_REQ,
  output logic [ADDR_W-1:0]  IM_ADDR,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_VALID,
  output logic               FETCH_BUSY,
  output logic               FETCH_ERR,
  output logic               FSM_STATE
);

  // Handshake: IM_REQ rises with a latched IM_ADDR and both stay stable until
  // the first cycle IM_ACK is sampled high (or the wait bound expires); the
  // word on IM_RDATA is taken in that same cycle. IM_ACK with no request is ignored.

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0]  pc_n, addr_n;
  logic [INSTR_W-1:0] ir_n;
  logic               req_n, valid_n, busy_n, err_n;

  assign FSM_STATE = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      PC         <= RESET_PC;
      IM_ADDR    <= RESET_PC;
      IR         <= '0;
      IM_REQ     <= 1'b0;
      IR_VALID   <= 1'b0;
      FETCH_BUSY <= 1'b0;
      FETCH_ERR  <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      PC         <= pc_n;
      IM_ADDR    <= addr_n;
      IR         <= ir_n;
      IM_REQ     <= req_n;
      IR_VALID   <= valid_n;
      FETCH_BUSY <= busy_n;
      FETCH_ERR  <= err_n;
    end
  end

  // PC runs independently of the fetch FSM; a fetch already holds its own address.
  always_comb begin
    pc_n = PC;
    if (PC_CLR)     pc_n = RESET_PC;
    else if (PC_LD) pc_n = PC_LD_VAL;
    else if (PC_IC) pc_n = PC + 1'b1;
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    addr_n     = IM_ADDR;
    ir_n       = IR;
    req_n      = IM_REQ;
    valid_n    = IR_VALID;
    busy_n     = FETCH_BUSY;
    err_n      = FETCH_ERR;
    case (state)
      S_IDLE: begin
        if (IR_LD) begin
          addr_n     = PC;
          req_n      = 1'b1;
          busy_n     = 1'b1;
          valid_n    = 1'b0;
          err_n      = 1'b0;
          wait_cnt_n = '0;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IM_ACK) begin
          ir_n    = IM_RDATA;
          valid_n = 1'b1;
          req_n   = 1'b0;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
          ir_n    = ERR_INSTR;
          valid_n = 1'b1;
          err_n   = 1'b1;
          req_n   = 1'b0;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, PC priority/wrap, fetch latency,
// timeout, ignored commands and mid-fetch reset.
module tb_pc_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        PC_CLR = 1'b0, PC_LD = 1'b0, PC_IC = 1'b0, IR_LD = 1'b0, IM_ACK = 1'b0;
  logic [7:0]  PC_LD_VAL = '0;
  logic [15:0] IM_RDATA = '0;
  logic        IM_REQ, IR_VALID, FETCH_BUSY, FETCH_ERR, FSM_STATE;
  logic [7:0]  IM_ADDR, PC;
  logic [15:0] IR;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .TIMEOUT(4), .ERR_INSTR(16'hDEAD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PC_CLR(PC_CLR), .PC_LD(PC_LD), .PC_LD_VAL(PC_LD_VAL),
    .PC_IC(PC_IC), .IR_LD(IR_LD), .IM_ACK(IM_ACK), .IM_RDATA(IM_RDATA), .IM_REQ(IM_REQ),
    .IM_ADDR(IM_ADDR), .PC(PC), .IR(IR), .IR_VALID(IR_VALID), .FETCH_BUSY(FETCH_BUSY),
    .FETCH_ERR(FETCH_ERR), .FSM_STATE(FSM_STATE)
  );

  always #5 Clock = ~Clock;

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (IM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", IM_REQ); end
    checks++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h exp 00", PC); end
    checks++; if (IM_ADDR !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h exp 00", IM_ADDR); end
    checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h exp 0000", IR); end
    checks++; if ({IR_VALID, FETCH_BUSY, FETCH_ERR, FSM_STATE} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {IR_VALID, FETCH_BUSY, FETCH_ERR, FSM_STATE});
    end
    Reset = 1'b1;
    step();
  endtask

  task automatic test_fetch_zero_wait();
    IR_LD = 1'b1;
    step();
    IR_LD = 1'b0; IM_ACK = 1'b1; IM_RDATA = 16'h1234;
    checks++; if (IM_REQ !== 1'b1) begin errors++; $display("FAIL zw_req_rise: got %b exp 1", IM_REQ); end
    checks++; if (IM_ADDR !== 8'h00) begin errors++; $display("FAIL zw_addr: got %h exp 00", IM_ADDR); end
    checks++; if ({IR_VALID, FETCH_BUSY} !== 2'b01) begin errors++; $display("FAIL zw_pending: got %b exp 01", {IR_VALID, FETCH_BUSY}); end
    step();
    IM_ACK = 1'b0;
    checks++; if (IR !== 16'h1234) begin errors++; $display("FAIL zw_ir: got %h exp 1234", IR); end
    checks++; if ({IR_VALID, IM_REQ, FETCH_BUSY, FETCH_ERR} !== 4'b1000) begin
      errors++; $display("FAIL zw_done: got %b exp 1000", {IR_VALID, IM_REQ, FETCH_BUSY, FETCH_ERR});
    end
  endtask

  task automatic test_pc_priority();
    PC_LD = 1'b1; PC_LD_VAL = 8'hFF;
    step();
    checks++; if (PC !== 8'hFF) begin errors++; $display("FAIL pc_load: got %h exp ff", PC); end
    PC_LD = 1'b0; PC_IC = 1'b1;
    step();
    checks++; if (PC !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h exp 00", PC); end
    PC_IC = 1'b1; PC_LD = 1'b1; PC_LD_VAL = 8'h33;
    step();
    checks++; if (PC !== 8'h33) begin errors++; $display("FAIL pc_ld_over_ic: got %h exp 33", PC); end
    PC_CLR = 1'b1; PC_LD_VAL = 8'hAA;
    step();
    checks++; if (PC !== 8'h00) begin errors++; $display("FAIL pc_clr_wins: got %h exp 00", PC); end
    PC_CLR = 1'b0; PC_LD = 1'b0; PC_IC = 1'b0;
  endtask

  task automatic test_fetch_wait();
    PC_LD = 1'b1; PC_LD_VAL = 8'h10;
    step();
    PC_LD = 1'b0; IR_LD = 1'b1; PC_IC = 1'b1;
    step();
    IR_LD = 1'b0; PC_IC = 1'b0;
    checks++; if (PC !== 8'h11) begin errors++; $display("FAIL fw_pc_inc: got %h exp 11", PC); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (IM_ADDR !== 8'h10) begin errors++; $display("FAIL fw_addr_%0d: got %h exp 10", i, IM_ADDR); end
      checks++; if ({IM_REQ, IR_VALID} !== 2'b10) begin errors++; $display("FAIL fw_wait_%0d: got %b exp 10", i, {IM_REQ, IR_VALID}); end
      if (i == 3) begin IM_ACK = 1'b1; IM_RDATA = 16'hABCD; end
      step();
    end
    IM_ACK = 1'b0;
    checks++; if (IR !== 16'hABCD) begin errors++; $display("FAIL fw_ir: got %h exp abcd", IR); end
    checks++; if ({IR_VALID, FETCH_ERR, IM_REQ} !== 3'b100) begin
      errors++; $display("FAIL fw_ack_wins: got %b exp 100", {IR_VALID, FETCH_ERR, IM_REQ});
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    IR_LD = 1'b1;
    step();
    IR_LD = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!IM_REQ) break;
      req_cycles++;
      step();
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_len: got %0d exp 4", req_cycles); end
    checks++; if (IR !== 16'hDEAD) begin errors++; $display("FAIL to_ir: got %h exp dead", IR); end
    checks++; if ({IR_VALID, FETCH_ERR, FETCH_BUSY} !== 3'b110) begin
      errors++; $display("FAIL to_flags: got %b exp 110", {IR_VALID, FETCH_ERR, FETCH_BUSY});
    end
    step();
    checks++; if (FETCH_ERR !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", FETCH_ERR); end
    IR_LD = 1'b1;
    step();
    IR_LD = 1'b0; IM_ACK = 1'b1; IM_RDATA = 16'h0F0F;
    checks++; if ({FETCH_ERR, IR_VALID} !== 2'b00) begin errors++; $display("FAIL to_err_clr: got %b exp 00", {FETCH_ERR, IR_VALID}); end
    step();
    IM_ACK = 1'b0;
    checks++; if (IR !== 16'h0F0F) begin errors++; $display("FAIL to_refetch: got %h exp 0f0f", IR); end
  endtask

  task automatic test_ignored();
    IM_ACK = 1'b1; IM_RDATA = 16'hFFFF;
    step();
    IM_ACK = 1'b0;
    checks++; if (IR !== 16'h0F0F) begin errors++; $display("FAIL ign_idle_ack_ir: got %h exp 0f0f", IR); end
    checks++; if ({FSM_STATE, IM_REQ} !== 2'b00) begin errors++; $display("FAIL ign_idle_ack_fsm: got %b exp 00", {FSM_STATE, IM_REQ}); end
    PC_LD = 1'b1; PC_LD_VAL = 8'h20;
    step();
    PC_LD = 1'b0; IR_LD = 1'b1;
    step();
    PC_LD = 1'b1; PC_LD_VAL = 8'h30;
    step();
    PC_LD = 1'b0; IR_LD = 1'b0;
    checks++; if (IM_ADDR !== 8'h20) begin errors++; $display("FAIL ign_wait_addr: got %h exp 20", IM_ADDR); end
    checks++; if ({FSM_STATE, IM_REQ} !== 2'b11) begin errors++; $display("FAIL ign_wait_fsm: got %b exp 11", {FSM_STATE, IM_REQ}); end
    IM_ACK = 1'b1; IM_RDATA = 16'h1111;
    step();
    IM_ACK = 1'b0;
    checks++; if (IR !== 16'h1111) begin errors++; $display("FAIL ign_ir: got %h exp 1111", IR); end
    step();
    checks++; if ({FSM_STATE, IM_REQ, IM_ADDR} !== {2'b00, 8'h20}) begin
      errors++; $display("FAIL ign_no_queue: got %b/%h exp 00/20", {FSM_STATE, IM_REQ}, IM_ADDR);
    end
  endtask

  task automatic test_reset_mid_wait();
    IR_LD = 1'b1;
    step();
    IR_LD = 1'b0;
    step();
    #2 Reset = 1'b0;
    #1;
    checks++; if (IM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req_drop: got %b exp 0", IM_REQ); end
    checks++; if ({PC, IM_ADDR, IR} !== 32'h0) begin errors++; $display("FAIL rst_regs: got %h/%h/%h exp 0", PC, IM_ADDR, IR); end
    checks++; if ({IR_VALID, FETCH_BUSY, FETCH_ERR, FSM_STATE} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b exp 0000", {IR_VALID, FETCH_BUSY, FETCH_ERR, FSM_STATE});
    end
    step();
    #2 Reset = 1'b1; IM_ACK = 1'b1; IM_RDATA = 16'hBEEF;
    step();
    IM_ACK = 1'b0;
    checks++; if ({IR, IR_VALID} !== 17'h0) begin errors++; $display("FAIL rst_late_ack: got %h/%b exp 0000/0", IR, IR_VALID); end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_pc_priority();
    test_fetch_wait();
    test_timeout();
    test_ignored();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
